// File: rtl/nim_pkg.sv
// Shared types and constants for the Nim rules engine.
package nim_pkg;

    typedef enum logic [1:0] {PICK, TAKING, DONE} nim_state_t;

    localparam logic NIM_LEFT  = 1'b0;
    localparam logic NIM_RIGHT = 1'b1;

    localparam int         NIM_NUM_PILES  = 3;
    localparam int         NIM_PILE_W     = 4;
    localparam logic [11:0] NIM_INIT_PILES = {4'd7, 4'd5, 4'd3};

endpackage

// File: rtl/nim_pile_bank.sv
// Pile count registers: reload, guarded decrement of the selected pile,
// and flags describing the selected pile and the rest of the bank.
module nim_pile_bank
    import nim_pkg::*;
#(
    parameter int                            NUM_PILES  = NIM_NUM_PILES,
    parameter int                            PILE_W     = NIM_PILE_W,
    parameter logic [NUM_PILES*PILE_W-1:0]   INIT_PILES = NIM_INIT_PILES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          dec,
    input  logic [1:0]                    sel,
    output logic [NUM_PILES*PILE_W-1:0]   piles,
    output logic                          sel_empty,
    output logic                          last_take
);

    logic [PILE_W-1:0] cnt;
    logic              sel_one;
    logic              others_zero;

    // An out-of-range selection reads as empty, so it can never be decremented.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cnt         = '0;
        sel_empty   = 1'b1;
        sel_one     = 1'b0;
        others_zero = 1'b1;
        for (int i = 0; i < NUM_PILES; i++) begin
            cnt = piles[i*PILE_W +: PILE_W];
            if (2'(i) == sel) begin
                sel_empty = (cnt == '0);
                sel_one   = (cnt == PILE_W'(1));
            end else if (cnt != '0) begin
                others_zero = 1'b0;
            end
        end
        last_take = sel_one && others_zero;
    end

    always_ff @(posedge clk) begin
        if (reset || load) begin
            piles <= INIT_PILES;
        end else if (dec && !sel_empty) begin
            for (int i = 0; i < NUM_PILES; i++) begin
                if (2'(i) == sel)
                    piles[i*PILE_W +: PILE_W] <= piles[i*PILE_W +: PILE_W] - PILE_W'(1);
            end
        end
    end

endmodule

// File: rtl/nim_turn_ctrl.sv
// Nim turn/rules FSM: tracks selection and turn, detects the winning take
// and emits a one-cycle score pulse for the scoreboard.
module nim_turn_ctrl
    import nim_pkg::*;
#(
    parameter int                            NUM_PILES  = NIM_NUM_PILES,
    parameter int                            PILE_W     = NIM_PILE_W,
    parameter logic [NUM_PILES*PILE_W-1:0]   INIT_PILES = NIM_INIT_PILES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_game,
    input  logic                          sel_next,
    input  logic                          take,
    input  logic                          end_turn,
    output logic                          inc_lp,
    output logic                          inc_rp,
    output logic                          turn,
    output logic [1:0]                    sel_pile,
    output logic [NUM_PILES*PILE_W-1:0]   piles,
    output logic                          game_over
);

    nim_state_t state;
    logic       sel_empty;
    logic       last_take;
    logic       dec;
    logic       win;

    // new_game outranks take; DONE freezes the piles.
    assign dec = take && !new_game && (state != DONE);
    assign win = dec && !sel_empty && last_take;

    nim_pile_bank #(
        .NUM_PILES  (NUM_PILES),
        .PILE_W     (PILE_W),
        .INIT_PILES (INIT_PILES)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .load      (new_game),
        .dec       (dec),
        .sel       (sel_pile),
        .piles     (piles),
        .sel_empty (sel_empty),
        .last_take (last_take)
    );

    always_ff @(posedge clk) begin
        // NOTE: score pulses default low every edge, so a win holds them for exactly one cycle.
        inc_lp <= 1'b0;
        inc_rp <= 1'b0;
        if (reset) begin
            state     <= PICK;
            turn      <= NIM_LEFT;
            sel_pile  <= 2'd0;
            game_over <= 1'b0;
        end else if (new_game) begin
            // The loser of a finished game moves first; an abandoned game keeps the turn.
            if (state == DONE)
                turn <= ~turn;
            state     <= PICK;
            sel_pile  <= 2'd0;
            game_over <= 1'b0;
        end else if (win) begin
            state     <= DONE;
            game_over <= 1'b1;
            inc_lp    <= (turn == NIM_LEFT);
            inc_rp    <= (turn == NIM_RIGHT);
        end else begin
            case (state)
                PICK: begin
                    if (take) begin
                        if (!sel_empty)
                            state <= TAKING;
                    end else if (sel_next && !end_turn) begin
                        sel_pile <= (sel_pile == 2'(NUM_PILES-1)) ? 2'd0 : sel_pile + 2'd1;
                    end
                end
                TAKING: begin
                    if (!take && end_turn) begin
                        turn  <= ~turn;
                        state <= PICK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nim_turn_ctrl.sv
// Directed bench for nim_turn_ctrl: each step queues its expected outputs,
// and a checker pops and compares them one cycle later.
module tb_nim_turn_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        sel_next = 1'b0;
    logic        take = 1'b0;
    logic        end_turn = 1'b0;
    logic        inc_lp;
    logic        inc_rp;
    logic        turn;
    logic [1:0]  sel_pile;
    logic [11:0] piles;
    logic        game_over;

    typedef struct {
        string       tag;
        logic [11:0] piles;
        logic        turn;
        logic [1:0]  sel;
        logic        go;
        logic        il;
        logic        ir;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_asserts = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nim_turn_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .new_game  (new_game),
        .sel_next  (sel_next),
        .take      (take),
        .end_turn  (end_turn),
        .inc_lp    (inc_lp),
        .inc_rp    (inc_rp),
        .turn      (turn),
        .sel_pile  (sel_pile),
        .piles     (piles),
        .game_over (game_over)
    );

    task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
        n_asserts++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit ng, input bit sn,
                        input bit tk, input bit et, input int p0, input int p1,
                        input int p2, input bit t, input int s, input bit go,
                        input bit il, input bit ir);
        exp_t e;
        @(negedge clk);
        e.tag   = tag;
        e.piles = {4'(p2), 4'(p1), 4'(p0)};
        e.turn  = t;
        e.sel   = 2'(s);
        e.go    = go;
        e.il    = il;
        e.ir    = ir;
        sb.push_back(e);
        reset    = r;
        new_game = ng;
        sel_next = sn;
        take     = tk;
        end_turn = et;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({cur.tag, ".piles"}, piles, cur.piles);
            chk({cur.tag, ".turn"}, 12'(turn), 12'(cur.turn));
            chk({cur.tag, ".sel_pile"}, 12'(sel_pile), 12'(cur.sel));
            chk({cur.tag, ".game_over"}, 12'(game_over), 12'(cur.go));
            chk({cur.tag, ".inc_lp"}, 12'(inc_lp), 12'(cur.il));
            chk({cur.tag, ".inc_rp"}, 12'(inc_rp), 12'(cur.ir));
        end
    end

    initial begin
        //    tag               r ng sn tk et  p0 p1 p2  t  s go il ir
        step("reset",           1, 0, 0, 0, 0, 3, 5, 7, 0, 0, 0, 0, 0);
        step("pick_end_turn",   0, 0, 0, 0, 1, 3, 5, 7, 0, 0, 0, 0, 0);
        step("sel1",            0, 0, 1, 0, 0, 3, 5, 7, 0, 1, 0, 0, 0);
        step("sel2",            0, 0, 1, 0, 0, 3, 5, 7, 0, 2, 0, 0, 0);
        step("sel_wrap",        0, 0, 1, 0, 0, 3, 5, 7, 0, 0, 0, 0, 0);
        step("take_p0",         0, 0, 0, 1, 0, 2, 5, 7, 0, 0, 0, 0, 0);
        step("sel_locked",      0, 0, 1, 0, 0, 2, 5, 7, 0, 0, 0, 0, 0);
        step("take_p0_b",       0, 0, 0, 1, 0, 1, 5, 7, 0, 0, 0, 0, 0);
        step("take_p0_c",       0, 0, 0, 1, 0, 0, 5, 7, 0, 0, 0, 0, 0);
        step("end_turn_l",      0, 0, 0, 0, 1, 0, 5, 7, 1, 0, 0, 0, 0);
        step("take_empty",      0, 0, 0, 1, 0, 0, 5, 7, 1, 0, 0, 0, 0);
        step("still_pick",      0, 0, 0, 0, 1, 0, 5, 7, 1, 0, 0, 0, 0);
        step("r_sel1",          0, 0, 1, 0, 0, 0, 5, 7, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("r_take_p1_%0d", i), 0, 0, 0, 1, 0, 0, 5-i, 7, 1, 1, 0, 0, 0);
        step("end_turn_r",      0, 0, 0, 0, 1, 0, 0, 7, 0, 1, 0, 0, 0);
        step("l_sel2",          0, 0, 1, 0, 0, 0, 0, 7, 0, 2, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            step($sformatf("l_take_p2_%0d", i), 0, 0, 0, 1, 0, 0, 0, 7-i, 0, 2, 0, 0, 0);
        step("end_turn_l2",     0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 0, 0, 0);
        step("r_win",           0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 1);
        step("done_idle",       0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        step("done_take",       0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        step("done_end_turn",   0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 1, 0, 0);
        step("done_sel",        0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        step("new_game_done",   0, 1, 0, 0, 0, 3, 5, 7, 0, 0, 0, 0, 0);
        step("g2_take",         0, 0, 0, 1, 0, 2, 5, 7, 0, 0, 0, 0, 0);
        step("take_and_end",    0, 0, 0, 1, 1, 1, 5, 7, 0, 0, 0, 0, 0);
        step("g2_end_turn",     0, 0, 0, 0, 1, 1, 5, 7, 1, 0, 0, 0, 0);
        step("g2_r_take",       0, 0, 0, 1, 0, 0, 5, 7, 1, 0, 0, 0, 0);
        step("new_game_mid",    0, 1, 1, 1, 1, 3, 5, 7, 1, 0, 0, 0, 0);
        step("mid_idle",        0, 0, 0, 0, 0, 3, 5, 7, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            step($sformatf("g3_take_p0_%0d", i), 0, 0, 0, 1, 0, 3-i, 5, 7, 1, 0, 0, 0, 0);
        step("g3_end_r",        0, 0, 0, 0, 1, 0, 5, 7, 0, 0, 0, 0, 0);
        step("g3_sel1",         0, 0, 1, 0, 0, 0, 5, 7, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("g3_take_p1_%0d", i), 0, 0, 0, 1, 0, 0, 5-i, 7, 0, 1, 0, 0, 0);
        step("g3_end_l",        0, 0, 0, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0);
        step("g3_sel2",         0, 0, 1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            step($sformatf("g3_take_p2_%0d", i), 0, 0, 0, 1, 0, 0, 0, 7-i, 1, 2, 0, 0, 0);
        step("g3_end_r2",       0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0);
        step("reset_on_win",    1, 0, 0, 1, 0, 3, 5, 7, 0, 0, 0, 0, 0);
        step("after_reset",     0, 0, 0, 0, 0, 3, 5, 7, 0, 0, 0, 0, 0);

        @(negedge clk);
        reset    = 1'b0;
        new_game = 1'b0;
        sel_next = 1'b0;
        take     = 1'b0;
        end_turn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 12'(sb.size()), 12'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
